// File: rtl/zbc_clmul.sv
// Multi-cycle carry-less multiplier (CLMUL/CLMULH/CLMULR) for the execute stage.
// Consumes BITS_PER_CYCLE multiplier bits per cycle and stops early once none remain set.
module zbc_clmul #(
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic        s_clk_i,
  input  logic        s_rst_i,
  input  logic        s_start_i,
  input  logic        s_flush_i,
  input  logic [1:0]  s_function_i,
  input  logic [31:0] s_op1_i,
  input  logic [31:0] s_op2_i,
  output logic        s_busy_o,
  output logic        s_valid_o,
  output logic [31:0] s_result_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [63:0] acc_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [1:0]  fn_q;
  logic        busy_q;
  logic        valid_q;
  logic [31:0] result_q;

  logic [63:0] acc_step;
  logic [63:0] mcand_step;
  logic [31:0] mplier_step;
  logic [31:0] run_result;

  // One RUN step: fold in up to BITS_PER_CYCLE partial products, then advance the operands.
  always_comb begin
    acc_step = acc_q;
    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier_q[j[4:0]]) begin
        acc_step = acc_step ^ (mcand_q << j);
      end
    end
    mcand_step  = mcand_q << BITS_PER_CYCLE;
    mplier_step = mplier_q >> BITS_PER_CYCLE;

    run_result = '0;
    case (fn_q)
      2'b00:   run_result = acc_step[31:0];
      2'b01:   run_result = acc_step[63:32];
      2'b10:   run_result = acc_step[62:31];
      default: run_result = '0;
    endcase
  end

  always_ff @(posedge s_clk_i or posedge s_rst_i) begin
    if (s_rst_i) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      fn_q     <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (s_flush_i) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (s_start_i) begin
              fn_q     <= s_function_i;
              mcand_q  <= {32'b0, s_op1_i};
              mplier_q <= s_op2_i;
              acc_q    <= '0;
              if (s_op2_i == '0) begin
                // Empty product: every function selects zero.
                state_q  <= StDone;
                valid_q  <= 1'b1;
                busy_q   <= 1'b0;
                result_q <= '0;
              end else begin
                state_q <= StRun;
                busy_q  <= 1'b1;
              end
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
          StRun: begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_step;
            mplier_q <= mplier_step;
            if (mplier_step == '0) begin
              state_q  <= StDone;
              valid_q  <= 1'b1;
              busy_q   <= 1'b0;
              result_q <= run_result;
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign s_busy_o   = busy_q;
  assign s_valid_o  = valid_q;
  assign s_result_o = result_q;

endmodule

// File: tb/tb_zbc_clmul.sv
// Self-checking bench for zbc_clmul: directed corners plus random operations checked
// against a bit-serial carry-less product model.
module tb_zbc_clmul;

  localparam int unsigned B = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [1:0]  fn;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int n_pass;
  int n_total;

  zbc_clmul #(.BITS_PER_CYCLE(B)) dut (
    .s_clk_i      (clk),
    .s_rst_i      (rst),
    .s_start_i    (start),
    .s_flush_i    (flush),
    .s_function_i (fn),
    .s_op1_i      (op1),
    .s_op2_i      (op2),
    .s_busy_o     (busy),
    .s_valid_o    (valid),
    .s_result_o   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] clmul_ref(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) p = p ^ ({32'b0, a} << i);
    end
    return p;
  endfunction

  function automatic logic [31:0] exp_result(input logic [1:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    p = clmul_ref(a, b);
    case (f)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return p[62:31];
      default: return 32'h0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
    int h;
    if (b == 0) return 0;
    h = 0;
    for (int i = 0; i < 32; i++) if (b[i]) h = i;
    return (h + 1 + int'(B) - 1) / int'(B);
  endfunction

  // Issues one operation from IDLE and returns in the cycle valid is high (or on timeout).
  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cycles, output logic [31:0] res);
    @(negedge clk);
    start = 1'b1; fn = f; op1 = a; op2 = b;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_cycles = 0;
    while (!valid && lat < 40) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'h0)
      $display("FAIL reset_outputs: busy=%b valid=%b result=%h, need 0/0/0", busy, valid, result);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  tf [9];
    logic [31:0] ta [9];
    logic [31:0] tb [9];
    logic [31:0] tr [9];
    int          tl [9];
    int lat, bc;
    logic [31:0] res;
    tf = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00};
    ta = '{32'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
           32'h80000000, 32'h80000000, 32'hDEADBEEF};
    tb = '{32'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
           32'h80000000, 32'h80000000, 32'h0};
    tr = '{32'h5, 32'h55555555, 32'h55555555, 32'hAAAAAAAA, 32'h40000000, 32'h80000000,
           32'h0, 32'h0, 32'h0};
    tl = '{1, 8, 8, 8, 8, 8, 8, 8, 0};
    for (int i = 0; i < 9; i++) begin
      run_op(tf[i], ta[i], tb[i], lat, bc, res);
      n_total++;
      if (res !== tr[i]) $display("FAIL directed_result[%0d]: got %h, need %h", i, res, tr[i]);
      else n_pass++;
      n_total++;
      if (lat != tl[i]) $display("FAIL directed_latency[%0d]: got %0d, need %0d", i, lat, tl[i]);
      else n_pass++;
      n_total++;
      if (bc != tl[i]) $display("FAIL directed_busy[%0d]: got %0d, need %0d", i, bc, tl[i]);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL valid_one_cycle: valid=%b busy=%b, need 0/0", valid, busy);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat, bc;
    logic [31:0] a, b, res;
    logic [1:0] f;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 32);
      f = 2'($urandom_range(0, 3));
      run_op(f, a, b, lat, bc, res);
      n_total++;
      if (res !== exp_result(f, a, b) || lat != exp_lat(b) || bc != exp_lat(b))
        $display("FAIL random[%0d] fn=%0d a=%h b=%h: got res=%h lat=%0d busy=%0d, need %h/%0d/%0d",
                 i, f, a, b, res, lat, bc, exp_result(f, a, b), exp_lat(b), exp_lat(b));
      else n_pass++;
    end
  endtask

  task automatic test_start_in_run();
    int lat;
    @(negedge clk);
    start = 1'b1; fn = 2'b00; op1 = 32'h12345678; op2 = 32'hF0000001;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; fn = 2'b01; op1 = 32'hFFFFFFFF; op2 = 32'h1;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (!valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_total++;
    if (result !== exp_result(2'b00, 32'h12345678, 32'hF0000001) || lat != 8)
      $display("FAIL start_in_run: got res=%h lat=%0d, need %h/8", result, lat,
               exp_result(2'b00, 32'h12345678, 32'hF0000001));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [31:0] res;
    run_op(2'b00, 32'hA5A5A5A5, 32'h0000_0F0F, lat, bc, res);
    n_total++;
    if (res !== exp_result(2'b00, 32'hA5A5A5A5, 32'h0F0F) || lat != 3)
      $display("FAIL b2b_first: got res=%h lat=%0d, need %h/3", res, lat,
               exp_result(2'b00, 32'hA5A5A5A5, 32'h0F0F));
    else n_pass++;
    // Still in the DONE cycle: the next start must be taken immediately.
    start = 1'b1; fn = 2'b01; op1 = 32'hCAFEF00D; op2 = 32'h00F0_0000;
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1) $display("FAIL b2b_no_gap: busy=%b, need 1", busy);
    else n_pass++;
    lat = 0;
    while (!valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_total++;
    if (result !== exp_result(2'b01, 32'hCAFEF00D, 32'h00F00000) || lat != 6)
      $display("FAIL b2b_second: got res=%h lat=%0d, need %h/6", result, lat,
               exp_result(2'b01, 32'hCAFEF00D, 32'h00F00000));
    else n_pass++;
  endtask

  task automatic test_start_flush();
    logic [31:0] prior;
    int seen;
    prior = result;
    @(negedge clk);
    start = 1'b1; flush = 1'b1; fn = 2'b00; op1 = 32'h7; op2 = 32'h0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy || valid) seen++;
      @(negedge clk);
    end
    n_total++;
    if (seen != 0 || result !== prior)
      $display("FAIL start_flush: busy/valid cycles=%0d result=%h, need 0 and %h",
               seen, result, prior);
    else n_pass++;
  endtask

  task automatic test_flush_abort();
    logic [31:0] prior;
    int seen;
    prior = result;
    @(negedge clk);
    start = 1'b1; fn = 2'b00; op1 = 32'h13579BDF; op2 = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL flush_busy: busy=%b, need 0", busy);
    else n_pass++;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid) seen++;
      @(negedge clk);
    end
    n_total++;
    if (seen != 0 || result !== prior)
      $display("FAIL flush_no_valid: valid cycles=%0d result=%h, need 0 and %h",
               seen, result, prior);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int lat, bc;
    logic [31:0] res;
    run_op(2'b00, 32'hFFFF0000, 32'h00000003, lat, bc, res);
    @(negedge clk);
    start = 1'b1; fn = 2'b00; op1 = 32'h2468ACE0; op2 = 32'h80000000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b1 || result === 32'h0)
      $display("FAIL pre_reset_state: busy=%b result=%h, need busy 1 and nonzero", busy, result);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'h0)
      $display("FAIL async_reset: busy=%b valid=%b result=%h, need 0/0/0", busy, valid, result);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b00, 32'h3, 32'h3, lat, bc, res);
    n_total++;
    if (res !== 32'h5 || lat != 1)
      $display("FAIL post_reset_op: got res=%h lat=%0d, need 5/1", res, lat);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    fn = 2'b00;
    op1 = '0;
    op2 = '0;
    test_reset();
    test_directed();
    test_random();
    test_start_in_run();
    test_back_to_back();
    test_start_flush();
    test_flush_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
